// File: rtl/bnn_feature_loader.sv
// Streams one sample's features into a flat vector, launches the sequential BNN
// classifier, captures its prediction and hands it downstream over valid/ready.
module bnn_feature_loader #(
  parameter int FEAT_CNT     = 19,
  parameter int FEAT_BITS    = 4,
  parameter int CLASS_CNT    = 3,
  parameter int INFER_CYCLES = 44,
  parameter int TEST_CNT     = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [FEAT_BITS-1:0]            in_feat,
  input  logic                            in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0]   features,
  output logic                            bnn_start,
  input  logic [$clog2(CLASS_CNT)-1:0]    bnn_pred,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]    out_pred,
  output logic                            err_len,
  output logic [$clog2(TEST_CNT+1)-1:0]   sample_cnt,
  output logic                            done
);

  localparam int IDX_W  = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int WAIT_W = $clog2(INFER_CYCLES + 1);
  localparam int CNT_W  = $clog2(TEST_CNT + 1);
  localparam int PRED_W = $clog2(CLASS_CNT);
  localparam int VEC_W  = FEAT_CNT * FEAT_BITS;

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FEAT_CNT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(INFER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TEST_CNT);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VEC_W-1:0]    feat_q, feat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [PRED_W-1:0]   pred_q, pred_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  // Next-state logic: feature packing, length check, inference wait, output handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    feat_d  = feat_q;
    wait_d  = wait_q;
    pred_d  = pred_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          feat_d[idx_q*FEAT_BITS +: FEAT_BITS] = in_feat;
          if ((idx_q == LAST_IDX) && in_last) begin
            state_d = S_START;
            idx_d   = {IDX_W{1'b0}};
          end else if ((idx_q == LAST_IDX) || in_last) begin
            // Wrong-length sample: drop it; the next sample overwrites the partial vector.
            err_d = 1'b1;
            idx_d = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_START: begin
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == {WAIT_W{1'b0}}) begin
          pred_d  = bnn_pred;
          state_d = S_OUT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_LOAD;
          if (cnt_q != CNT_LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_LOAD;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
      idx_q   <= {IDX_W{1'b0}};
      feat_q  <= {VEC_W{1'b0}};
      wait_q  <= {WAIT_W{1'b0}};
      pred_q  <= {PRED_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      feat_q  <= feat_d;
      wait_q  <= wait_d;
      pred_q  <= pred_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign bnn_start  = (state_q == S_START);
  assign out_valid  = (state_q == S_OUT);
  assign features   = feat_q;
  assign out_pred   = pred_q;
  assign err_len    = err_q;
  assign sample_cnt = cnt_q;
  assign done       = (cnt_q == CNT_LIMIT);

endmodule

// File: tb/tb_bnn_feature_loader.sv
// Directed bench for bnn_feature_loader with a small classifier model whose
// prediction is only correct from INFER_CYCLES cycles after bnn_start.
module tb_bnn_feature_loader;

  localparam int FEAT_CNT  = 19;
  localparam int FEAT_BITS = 4;
  localparam int CLASS_CNT = 3;
  localparam int INFER     = 44;
  localparam int TEST_CNT  = 3;
  localparam int FW        = FEAT_CNT * FEAT_BITS;
  localparam int PW        = $clog2(CLASS_CNT);
  localparam int CW        = $clog2(TEST_CNT + 1);

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [FEAT_BITS-1:0] in_feat;
  logic                 in_last;
  logic [FW-1:0]        features;
  logic                 bnn_start;
  logic [PW-1:0]        bnn_pred;
  logic                 out_valid;
  logic                 out_ready;
  logic [PW-1:0]        out_pred;
  logic                 err_len;
  logic [CW-1:0]        sample_cnt;
  logic                 done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PW-1:0] pred_want;
  int            m_cnt;
  logic [FW-1:0] exp_feat;

  bnn_feature_loader #(
    .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .CLASS_CNT(CLASS_CNT),
    .INFER_CYCLES(INFER), .TEST_CNT(TEST_CNT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_feat(in_feat), .in_last(in_last), .features(features),
    .bnn_start(bnn_start), .bnn_pred(bnn_pred), .out_valid(out_valid),
    .out_ready(out_ready), .out_pred(out_pred), .err_len(err_len),
    .sample_cnt(sample_cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Classifier model: correct answer only once INFER cycles have elapsed since start.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_cnt <= 0;
    else if (bnn_start) m_cnt <= 1;
    else if (m_cnt != 0 && m_cnt < 1000) m_cnt <= m_cnt + 1;
  end
  assign bnn_pred = (m_cnt >= INFER) ? pred_want : (pred_want ^ 2'b01);

  task automatic drive_beat(input logic [3:0] f, input logic l);
    in_valid = 1'b1; in_feat = f; in_last = l;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output int cyc, output int starts);
    cyc = 0; starts = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bnn_start) starts++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_feat = 4'h0; in_last = 1'b0;
    out_ready = 1'b0; pred_want = 2'd0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (features !== {FW{1'b0}}) begin n_bad++; $display("FAIL reset_features got %h want 0", features); end
    n_cmp++; if ({bnn_start, out_valid, err_len, done} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {bnn_start, out_valid, err_len, done}); end
    n_cmp++; if ({out_pred, sample_cnt} !== 4'h0) begin n_bad++; $display("FAIL reset_pred_cnt got %h want 0", {out_pred, sample_cnt}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    for (int i = 0; i < FEAT_CNT; i++) drive_beat(4'(i + 3), i == FEAT_CNT - 1);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (sample_cnt !== 2'd0) begin n_bad++; $display("FAIL midrst_cnt got %0d want 0", sample_cnt); end
    n_cmp++; if (features !== {FW{1'b0}}) begin n_bad++; $display("FAIL midrst_features got %h want 0", features); end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid || bnn_start) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_output got %0d want 0", seen); end
  endtask

  task automatic test_basic();
    int cyc, starts;
    pred_want = 2'd2; out_ready = 1'b1;
    for (int i = 0; i < FEAT_CNT; i++) exp_feat[i*4 +: 4] = 4'(i);
    for (int i = 0; i < FEAT_CNT; i++) drive_beat(4'(i), i == FEAT_CNT - 1);
    n_cmp++; if (features !== exp_feat) begin n_bad++; $display("FAIL basic_features got %h want %h", features, exp_feat); end
    n_cmp++; if ({features[75:72], features[3:0]} !== 8'h20) begin n_bad++; $display("FAIL basic_feat_ends got %h want 20", {features[75:72], features[3:0]}); end
    n_cmp++; if ({bnn_start, in_ready} !== 2'b10) begin n_bad++; $display("FAIL basic_start got %b want 10", {bnn_start, in_ready}); end
    wait_out(cyc, starts);
    n_cmp++; if (cyc !== 45) begin n_bad++; $display("FAIL basic_latency got %0d want 45", cyc); end
    n_cmp++; if (starts !== 0) begin n_bad++; $display("FAIL basic_start_once got %0d want 0", starts); end
    n_cmp++; if (out_pred !== 2'd2) begin n_bad++; $display("FAIL basic_pred got %0d want 2", out_pred); end
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready, done} !== 3'b010) begin n_bad++; $display("FAIL basic_after got %b want 010", {out_valid, in_ready, done}); end
    n_cmp++; if (sample_cnt !== 2'd1) begin n_bad++; $display("FAIL basic_cnt got %0d want 1", sample_cnt); end
  endtask

  task automatic test_short_sample();
    int cyc, starts;
    for (int i = 0; i < 5; i++) drive_beat(4'hA, i == 4);
    n_cmp++; if ({err_len, bnn_start, in_ready} !== 3'b101) begin n_bad++; $display("FAIL short_err got %b want 101", {err_len, bnn_start, in_ready}); end
    @(negedge clk);
    n_cmp++; if ({err_len, bnn_start} !== 2'b00) begin n_bad++; $display("FAIL short_err_pulse got %b want 00", {err_len, bnn_start}); end
    pred_want = 2'd1;
    for (int i = 0; i < FEAT_CNT; i++) exp_feat[i*4 +: 4] = 4'(i) ^ 4'hF;
    for (int i = 0; i < FEAT_CNT; i++) drive_beat(4'(i) ^ 4'hF, i == FEAT_CNT - 1);
    n_cmp++; if (features !== exp_feat) begin n_bad++; $display("FAIL short_next_features got %h want %h", features, exp_feat); end
    wait_out(cyc, starts);
    n_cmp++; if (cyc !== 45) begin n_bad++; $display("FAIL short_next_latency got %0d want 45", cyc); end
    n_cmp++; if (out_pred !== 2'd1) begin n_bad++; $display("FAIL short_next_pred got %0d want 1", out_pred); end
    @(negedge clk);
    n_cmp++; if (sample_cnt !== 2'd2) begin n_bad++; $display("FAIL short_next_cnt got %0d want 2", sample_cnt); end
  endtask

  task automatic test_no_last();
    for (int i = 0; i < FEAT_CNT; i++) drive_beat(4'h5, 1'b0);
    n_cmp++; if ({err_len, bnn_start, in_ready} !== 3'b101) begin n_bad++; $display("FAIL nolast_err got %b want 101", {err_len, bnn_start, in_ready}); end
    out_ready = 1'b0; pred_want = 2'd0;
    for (int i = 0; i < FEAT_CNT; i++) exp_feat[i*4 +: 4] = 4'(i * 3);
    for (int i = 0; i < FEAT_CNT; i++) drive_beat(4'(i * 3), i == FEAT_CNT - 1);
    n_cmp++; if (features !== exp_feat) begin n_bad++; $display("FAIL nolast_idx_reset got %h want %h", features, exp_feat); end
    n_cmp++; if (bnn_start !== 1'b1) begin n_bad++; $display("FAIL nolast_next_start got %0b want 1", bnn_start); end
  endtask

  task automatic test_out_hold();
    int cyc, starts, bad;
    wait_out(cyc, starts);
    n_cmp++; if (cyc !== 45) begin n_bad++; $display("FAIL hold_latency got %0d want 45", cyc); end
    n_cmp++; if (out_pred !== 2'd0) begin n_bad++; $display("FAIL hold_pred got %0d want 0", out_pred); end
    pred_want = 2'd2;
    in_valid = 1'b1; in_feat = 4'hF; in_last = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_pred !== 2'd0 || in_ready !== 1'b0 || features !== exp_feat) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL hold_release got %b want 01", {out_valid, in_ready}); end
    n_cmp++; if (features !== exp_feat) begin n_bad++; $display("FAIL hold_features_after got %h want %h", features, exp_feat); end
    n_cmp++; if ({sample_cnt, done} !== 3'b111) begin n_bad++; $display("FAIL hold_cnt_done got %b want 111", {sample_cnt, done}); end
  endtask

  task automatic test_saturate();
    int cyc, starts;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if ({sample_cnt, done} !== 3'b000) begin n_bad++; $display("FAIL sat_reset got %b want 000", {sample_cnt, done}); end
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      pred_want = 2'(s % 3);
      for (int i = 0; i < FEAT_CNT; i++) exp_feat[i*4 +: 4] = 4'(i + s);
      for (int i = 0; i < FEAT_CNT; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        drive_beat(4'(i + s), i == FEAT_CNT - 1);
      end
      n_cmp++; if (features !== exp_feat) begin n_bad++; $display("FAIL sat_features_%0d got %h want %h", s, features, exp_feat); end
      wait_out(cyc, starts);
      n_cmp++; if (out_pred !== 2'(s % 3)) begin n_bad++; $display("FAIL sat_pred_%0d got %0d want %0d", s, out_pred, s % 3); end
      @(negedge clk);
      n_cmp++; if (sample_cnt !== 2'((s < 2) ? s + 1 : 3)) begin n_bad++; $display("FAIL sat_cnt_%0d got %0d want %0d", s, sample_cnt, (s < 2) ? s + 1 : 3); end
      n_cmp++; if (done !== (s >= 2)) begin n_bad++; $display("FAIL sat_done_%0d got %0b want %0b", s, done, s >= 2); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_basic();
    test_short_sample();
    test_no_last();
    test_out_hold();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
